// File: rtl/keypad_matrix_emulator_if.sv
// ---------------------------------------------------------------------------
// keypad_matrix_emulator_if
//   Valid/ready channel that carries key codes into the keypad emulator.
//
//   Signals:
//     key_valid  - key_code is offered this cycle (driven by the sender)
//     key_code   - [3:2] row index, [1:0] column index (driven by the sender)
//     key_ready  - emulator queue can accept a code (driven by the emulator)
//
//   Modports:
//     master - key sender (testbench, command source)
//     slave  - keypad_matrix_emulator
// ---------------------------------------------------------------------------
interface keypad_matrix_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_matrix_emulator.sv
// ---------------------------------------------------------------------------
// keypad_matrix_emulator
//   4x4 keypad model driving the far end of a row/column scanned matrix.
//   Key codes arrive over a valid/ready channel into a small FIFO; each code
//   is replayed as a press of HOLD_CYCLES followed by RELEASE_CYCLES with all
//   keys open. While a key is closed, its row line follows its column line,
//   exactly as a real switch would.
//
//   Ports:
//     CLK        - system clock, rising edge
//     CLR        - asynchronous active-low reset
//     kbus       - key code channel (slave side: key_valid/key_code in,
//                  key_ready out)
//     Column     - scanner column drive, active-low
//     Row        - row sense lines, active-low, 1 = open
//     busy       - pressing/releasing or codes still queued
//     pressed    - high while a key is held closed
//     fifo_count - number of queued codes
//
//   Optional feature (compile-time macro KEYPAD_EMU_BOUNCE_EN):
//     Adds contact bounce driven by an 8-bit LFSR during the first
//     BOUNCE_CYCLES cycles of both the press and the release.
// ---------------------------------------------------------------------------
module keypad_matrix_emulator #(
  parameter int HOLD_CYCLES    = 2500000,
  parameter int RELEASE_CYCLES = 2500000,
  parameter int FIFO_DEPTH     = 4,
  parameter int BOUNCE_CYCLES  = 64
) (
  input  logic                          CLK,
  input  logic                          CLR,
  keypad_matrix_emulator_if.slave       kbus,
  input  logic [3:0]                    Column,
  output logic [3:0]                    Row,
  output logic                          busy,
  output logic                          pressed,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Counter sized for the longest phase and for the bounce thresholds,
  // so every comparison against it shares one width.
  localparam int CTR_MAX_HR = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int CTR_MAX    = (CTR_MAX_HR > BOUNCE_CYCLES) ? CTR_MAX_HR : BOUNCE_CYCLES;
  localparam int CTR_W      = $clog2(CTR_MAX + 1);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

  logic [3:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  state_t           r_state,   w_state_nx;
  logic [CTR_W-1:0] r_counter, w_counter_nx;
  logic [3:0]       r_cur_key, w_cur_key_nx;

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_contact;

  // Ready comes from the registered count only; a pop in the same cycle
  // does not open a slot early.
  assign w_ready        = (r_count != CNT_W'(FIFO_DEPTH));
  assign kbus.key_ready = w_ready;
  assign w_push         = kbus.key_valid & w_ready;

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define which entries are meaningful, so clearing the array buys nothing.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= kbus.key_code;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state   <= IDLE;
      r_counter <= '0;
      r_cur_key <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_counter <= w_counter_nx;
      r_cur_key <= w_cur_key_nx;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave one unassigned and infer a latch.
    w_state_nx   = r_state;
    w_counter_nx = r_counter;
    w_cur_key_nx = r_cur_key;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_cur_key_nx = r_mem[r_rd_ptr];
          w_counter_nx = CTR_W'(HOLD_CYCLES - 1);
          w_state_nx   = PRESS;
        end
      end
      PRESS: begin
        if (r_counter == '0) begin
          w_counter_nx = CTR_W'(RELEASE_CYCLES - 1);
          w_state_nx   = RELEASE;
        end else begin
          w_counter_nx = r_counter - 1'b1;
        end
      end
      RELEASE: begin
        if (r_counter == '0) w_state_nx = IDLE;
        else                 w_counter_nx = r_counter - 1'b1;
      end
      default: w_state_nx = IDLE;
    endcase
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
  logic [7:0] r_lfsr;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_lfsr <= 8'hA5;
    else      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  // The counter loads N-1 on entry and counts down, so the first
  // BOUNCE_CYCLES cycles of a phase are those with counter >= N-BOUNCE.
  // A phase no longer than the window bounces for its whole length.
  localparam int PRESS_THR = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES - BOUNCE_CYCLES : 0;
  localparam int REL_THR   = (RELEASE_CYCLES > BOUNCE_CYCLES) ? RELEASE_CYCLES - BOUNCE_CYCLES : 0;

  always_comb begin
    w_contact = 1'b0;
    case (r_state)
      PRESS:   w_contact = (r_counter >= CTR_W'(PRESS_THR)) ? r_lfsr[0] : 1'b1;
      RELEASE: w_contact = (r_counter >= CTR_W'(REL_THR))   ? r_lfsr[0] : 1'b0;
      default: w_contact = 1'b0;
    endcase
  end
`else
  assign w_contact = (r_state == PRESS);
`endif

  // Switch model: a closed contact ties the key's row to its column, so the
  // row follows the column drive combinationally. Other columns are ignored.
  always_comb begin
    Row = 4'b1111;
    if (w_contact) Row[r_cur_key[3:2]] = Column[r_cur_key[1:0]];
  end

  assign pressed    = (r_state == PRESS);
  assign busy       = (r_state != IDLE) | (r_count != '0);
  assign fifo_count = r_count;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// ---------------------------------------------------------------------------
// tb_keypad_matrix_emulator
//   Directed bench for keypad_matrix_emulator with HOLD_CYCLES=8,
//   RELEASE_CYCLES=4, FIFO_DEPTH=4 (clean-contact build). Inputs change and
//   outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_keypad_matrix_emulator;

  localparam int HOLD  = 8;
  localparam int REL   = 4;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [3:0] Column;
  logic [3:0] Row;
  logic       busy;
  logic       pressed;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  keypad_matrix_emulator_if kif ();

  keypad_matrix_emulator #(
    .HOLD_CYCLES    (HOLD),
    .RELEASE_CYCLES (REL),
    .FIFO_DEPTH     (DEPTH),
    .BOUNCE_CYCLES  (6)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .kbus       (kif),
    .Column     (Column),
    .Row        (Row),
    .busy       (busy),
    .pressed    (pressed),
    .fifo_count (fifo_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until pressed reaches lvl; an expired bound fails.
  task automatic wait_pressed(input logic lvl, input string tag);
    int n = 0;
    while (pressed !== lvl && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check(tag, {31'b0, pressed}, {31'b0, lvl});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  // Offer one code for a single cycle (FIFO must have room).
  task automatic push_one(input logic [3:0] code);
    kif.key_valid = 1'b1;
    kif.key_code  = code;
    @(negedge CLK);
    kif.key_valid = 1'b0;
  endtask

  logic [3:0] codes   [5];
  logic [3:0] exp_row [5];
  int         seen;

  initial begin
    // ---------------- 1: reset ----------------
    CLR           = 1'b0;
    Column        = 4'b0000;
    kif.key_valid = 1'b0;
    kif.key_code  = 4'b0000;
    #23;
    check("rst_row",   {28'b0, Row}, 32'hF);
    check("rst_ready", {31'b0, kif.key_ready}, 32'd1);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_count", {29'b0, fifo_count}, 32'd0);
    check("rst_press", {31'b0, pressed}, 32'd0);
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);

    // ---------------- 2: single press timing ----------------
    Column = 4'b1101;
    push_one(4'b1001);
    check("t2_count_after_push", {29'b0, fifo_count}, 32'd1);
    check("t2_not_yet_pressed", {31'b0, pressed}, 32'd0);
    check("t2_busy_queued", {31'b0, busy}, 32'd1);
    @(negedge CLK);
    for (int i = 0; i < HOLD; i++) begin
      check($sformatf("t2_press_%0d", i), {31'b0, pressed}, 32'd1);
      check($sformatf("t2_row_%0d", i), {28'b0, Row}, 32'b1011);
      @(negedge CLK);
    end
    for (int i = 0; i < REL; i++) begin
      check($sformatf("t2_rel_press_%0d", i), {31'b0, pressed}, 32'd0);
      check($sformatf("t2_rel_row_%0d", i), {28'b0, Row}, 32'hF);
      check($sformatf("t2_rel_busy_%0d", i), {31'b0, busy}, 32'd1);
      @(negedge CLK);
    end
    check("t2_busy_fall", {31'b0, busy}, 32'd0);

    // ---------------- 3: Row follows Column without a clock ----------------
    push_one(4'b1001);
    wait_pressed(1'b1, "t3_pressed");
    Column = 4'b1110;
    #1;
    check("t3_row_col_high", {28'b0, Row}, 32'hF);
    Column = 4'b1101;
    #1;
    check("t3_row_col_low", {28'b0, Row}, 32'b1011);
    wait_idle("t3_idle");

    // ---------------- 4: FIFO fill, back-pressure, FIFO order -------------
    // Column 1010: columns 0 and 2 driven low, 1 and 3 high.
    Column     = 4'b1010;
    codes[0]   = 4'b0000; exp_row[0] = 4'b1110;  // row0 col0
    codes[1]   = 4'b0110; exp_row[1] = 4'b1101;  // row1 col2
    codes[2]   = 4'b1000; exp_row[2] = 4'b1011;  // row2 col0
    codes[3]   = 4'b1110; exp_row[3] = 4'b0111;  // row3 col2
    codes[4]   = 4'b0100; exp_row[4] = 4'b1101;  // row1 col0
    push_one(4'b1100);                           // row3 col0 keeps FSM busy
    @(negedge CLK);
    check("t4_x_pressed", {31'b0, pressed}, 32'd1);
    check("t4_x_row", {28'b0, Row}, 32'b0111);
    kif.key_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      kif.key_code = codes[i];
      @(negedge CLK);
      check($sformatf("t4_fill_count_%0d", i), {29'b0, fifo_count}, i + 1);
      check($sformatf("t4_fill_ready_%0d", i), {31'b0, kif.key_ready}, (i < DEPTH - 1) ? 32'd1 : 32'd0);
    end
    kif.key_code = codes[4];
    @(negedge CLK);
    check("t4_held_ready", {31'b0, kif.key_ready}, 32'd0);
    check("t4_held_count", {29'b0, fifo_count}, 32'd4);
    begin
      int n = 0;
      while (kif.key_ready !== 1'b1 && n < 100) begin
        @(negedge CLK);
        n++;
      end
    end
    check("t4_ready_return", {31'b0, kif.key_ready}, 32'd1);
    check("t4_a_pressed", {31'b0, pressed}, 32'd1);
    check("t4_a_count", {29'b0, fifo_count}, 32'd3);
    check("t4_a_row", {28'b0, Row}, {28'b0, exp_row[0]});
    @(negedge CLK);
    kif.key_valid = 1'b0;
    check("t4_e_accepted", {29'b0, fifo_count}, 32'd4);
    for (int i = 1; i < 5; i++) begin
      wait_pressed(1'b0, $sformatf("t4_release_%0d", i));
      wait_pressed(1'b1, $sformatf("t4_press_%0d", i));
      check($sformatf("t4_row_%0d", i), {28'b0, Row}, {28'b0, exp_row[i]});
      check($sformatf("t4_count_%0d", i), {29'b0, fifo_count}, 4 - i);
    end
    wait_idle("t4_idle");

    // ---------------- 5: reset mid-press with codes queued ----------------
    push_one(4'b0000);
    @(negedge CLK);
    check("t5_pressed", {31'b0, pressed}, 32'd1);
    check("t5_row", {28'b0, Row}, 32'b1110);
    push_one(4'b1000);
    push_one(4'b0110);
    check("t5_queued", {29'b0, fifo_count}, 32'd2);
    #2;
    CLR = 1'b0;
    #1;
    check("t5_row_async", {28'b0, Row}, 32'hF);
    check("t5_count_clr", {29'b0, fifo_count}, 32'd0);
    check("t5_press_clr", {31'b0, pressed}, 32'd0);
    @(negedge CLK);
    CLR  = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (pressed === 1'b1 || Row !== 4'hF) seen++;
    end
    check("t5_no_press_after", seen, 32'd0);
    check("t5_busy_after", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
